instruction_fetch: RTL and testbench

Fetch stage directly upstream of the NBBPU datapath. Takes the datapath's current `PC` and reads the 16-bit instruction at that address from a byte-wide memory in two handshaked byte transfers. It assembles the two bytes little-endian and presents the result to the datapath's `instruction` input with a valid/ready handshake. A misaligned PC or an unresponsive memory raises a sticky fault.

---
 rtl/nbbpu_pkg.sv | 15 +
 rtl/instruction_fetch_if.sv | 25 ++
 rtl/instruction_fetch_timer.sv | 30 +++
 rtl/instruction_fetch.sv | 130 +++++++++++++
 tb/tb_instruction_fetch.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/nbbpu_pkg.sv
// Shared NBBPU definitions: fetch state encoding, datapath widths and the
// default memory-transfer timeout.
package nbbpu_pkg;
  localparam int INSTR_W            = 16;
  localparam int BYTE_W             = 8;
  localparam int TIMEOUT_CYCLES_DEF = 255;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REQ_LO = 3'd1,
    REQ_HI = 3'd2,
    VALID  = 3'd3,
    FAULT  = 3'd4
  } fetch_state_e;
endpackage

// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus: datapath-side instruction handshake plus the byte-wide
// memory request/ack channel. master = fetch unit, slave = datapath + memory.
interface instruction_fetch_if;
  import nbbpu_pkg::*;

  logic [INSTR_W-1:0] PC;
  logic               instr_ready;
  logic [INSTR_W-1:0] instruction;
  logic               instr_valid;
  logic               mem_req;
  logic [INSTR_W-1:0] mem_addr;
  logic [BYTE_W-1:0]  mem_rdata;
  logic               mem_ack;
  logic               fault;

  modport master (
    input  PC, instr_ready, mem_rdata, mem_ack,
    output instruction, instr_valid, mem_req, mem_addr, fault
  );

  modport slave (
    output PC, instr_ready, mem_rdata, mem_ack,
    input  instruction, instr_valid, mem_req, mem_addr, fault
  );
endinterface

// File: rtl/instruction_fetch_timer.sv
// fetch_timer: saturating wait counter. expired is asserted combinationally
// in the cycle that would bring the count to LIMIT, so the FSM can leave then.
module fetch_timer #(
  parameter int LIMIT = 255
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr)
      count_d = '0;
    else if (en && (count_q != CW'(LIMIT)))
      count_d = count_q + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign expired = en && (count_q >= CW'(LIMIT - 1));
endmodule

// File: rtl/instruction_fetch.sv
// Two-byte little-endian instruction fetch for the NBBPU datapath.
// Optional transfer timeout is enabled by defining FETCH_TIMEOUT_EN.
module instruction_fetch
  import nbbpu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input logic                clock,
  input logic                reset,
  instruction_fetch_if.master bus
);
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("instruction_fetch: TIMEOUT_CYCLES must be >= 1");
  end

  fetch_state_e       state_q, state_d;
  logic [INSTR_W-1:0] fetch_addr_q, fetch_addr_d;
  logic [BYTE_W-1:0]  lo_byte_q, lo_byte_d;
  logic [INSTR_W-1:0] instruction_q, instruction_d;
  logic               instr_valid_q, instr_valid_d;
  logic               mem_req_q, mem_req_d;
  logic [INSTR_W-1:0] mem_addr_q, mem_addr_d;
  logic               fault_q, fault_d;
  logic               timeout;

`ifdef FETCH_TIMEOUT_EN
  logic tmr_clr;
  // Cleared on every entry into a request state, i.e. once per byte.
  assign tmr_clr = ((state_q == IDLE) && !bus.PC[0]) ||
                   ((state_q == REQ_LO) && bus.mem_ack);

  fetch_timer #(.LIMIT(TIMEOUT_CYCLES)) u_timer (
    .clock   (clock),
    .reset   (reset),
    .clr     (tmr_clr),
    .en      (mem_req_q && !bus.mem_ack),
    .expired (timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    fetch_addr_d  = fetch_addr_q;
    lo_byte_d     = lo_byte_q;
    instruction_d = instruction_q;
    instr_valid_d = instr_valid_q;
    mem_req_d     = mem_req_q;
    mem_addr_d    = mem_addr_q;
    fault_d       = fault_q;
    unique case (state_q)
      IDLE: begin
        if (bus.PC[0]) begin
          state_d = FAULT;
          fault_d = 1'b1;
        end else begin
          fetch_addr_d = bus.PC;
          mem_addr_d   = bus.PC;
          mem_req_d    = 1'b1;
          state_d      = REQ_LO;
        end
      end
      REQ_LO: begin
        if (bus.mem_ack) begin
          lo_byte_d  = bus.mem_rdata;
          mem_addr_d = fetch_addr_q + 16'd1;
          state_d    = REQ_HI;
        end else if (timeout) begin
          mem_req_d = 1'b0;
          fault_d   = 1'b1;
          state_d   = FAULT;
        end
      end
      REQ_HI: begin
        if (bus.mem_ack) begin
          instruction_d = {bus.mem_rdata, lo_byte_q};
          instr_valid_d = 1'b1;
          mem_req_d     = 1'b0;
          state_d       = VALID;
        end else if (timeout) begin
          mem_req_d = 1'b0;
          fault_d   = 1'b1;
          state_d   = FAULT;
        end
      end
      VALID: begin
        // A PC change while stalled is a jump: drop the word and refetch.
        if (bus.instr_ready || (bus.PC != fetch_addr_q)) begin
          instr_valid_d = 1'b0;
          state_d       = IDLE;
        end
      end
      FAULT: begin
        mem_req_d     = 1'b0;
        instr_valid_d = 1'b0;
        fault_d       = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      fetch_addr_q  <= '0;
      lo_byte_q     <= '0;
      instruction_q <= '0;
      instr_valid_q <= 1'b0;
      mem_req_q     <= 1'b0;
      mem_addr_q    <= '0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      fetch_addr_q  <= fetch_addr_d;
      lo_byte_q     <= lo_byte_d;
      instruction_q <= instruction_d;
      instr_valid_q <= instr_valid_d;
      mem_req_q     <= mem_req_d;
      mem_addr_q    <= mem_addr_d;
      fault_q       <= fault_d;
    end
  end

  assign bus.instruction = instruction_q;
  assign bus.instr_valid = instr_valid_q;
  assign bus.mem_req     = mem_req_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.fault       = fault_q;
endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: byte-memory responder with
// programmable wait states, address and instruction scoreboards.
module tb_instruction_fetch;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  instruction_fetch_if ifc();

  instruction_fetch #(.TIMEOUT_CYCLES(4)) dut (
    .clock (clk),
    .reset (reset),
    .bus   (ifc)
  );

  int checks   = 0;
  int failures = 0;

  logic [7:0]  mem [0:65535];
  logic [15:0] sb[$];
  logic [15:0] addr_exp[$];
  logic        mem_en    = 1'b0;
  int          wait_cfg  = 0;
  int          wcnt      = 0;
  logic        resp_ack  = 1'b0;
  logic        stray_ack = 1'b0;

  assign ifc.mem_ack = resp_ack | stray_ack;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk); @(negedge clk);
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin cyc(); n++; end while (!ifc.instr_valid && n < 50);
  endtask

  // Memory responder: acks after wait_cfg idle cycles, checks each acked address.
  always @(negedge clk) begin
    if (mem_en && ifc.mem_req && !reset) begin
      if (wcnt >= wait_cfg) begin
        resp_ack      = 1'b1;
        ifc.mem_rdata = mem[ifc.mem_addr];
        wcnt          = 0;
        chk("addr_q_nonempty", addr_exp.size() != 0, 1);
        if (addr_exp.size() != 0) chk("mem_addr", ifc.mem_addr, addr_exp.pop_front());
      end else begin
        resp_ack = 1'b0;
        wcnt++;
      end
    end else begin
      resp_ack = 1'b0;
      wcnt     = 0;
    end
  end

  // Instruction scoreboard: compare on every accepted word.
  always @(negedge clk) begin
    if (!reset && ifc.instr_valid && ifc.instr_ready) begin
      chk("sb_nonempty", sb.size() != 0, 1);
      if (sb.size() != 0) chk("instruction", ifc.instruction, sb.pop_front());
    end
  end

  task automatic fetch(input logic [15:0] pc, input logic [7:0] lo, input logic [7:0] hi,
                       input int waits, input int exp_cyc, input string tag);
    int n;
    mem[pc] = lo;
    mem[pc + 16'd1] = hi;
    wait_cfg = waits;
    mem_en = 1'b1;
    ifc.PC = pc;
    ifc.instr_ready = 1'b1;
    sb.push_back({hi, lo});
    addr_exp.push_back(pc);
    addr_exp.push_back(pc + 16'd1);
    wait_valid(n);
    chk({tag, "_latency"}, n, exp_cyc);
    cyc();
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_instruction"}, ifc.instruction, 16'h0000);
    chk({tag, "_instr_valid"}, ifc.instr_valid, 1'b0);
    chk({tag, "_mem_req"},     ifc.mem_req,     1'b0);
    chk({tag, "_mem_addr"},    ifc.mem_addr,    16'h0000);
    chk({tag, "_fault"},       ifc.fault,       1'b0);
  endtask

  initial begin
    int   n;
    logic bad;
    reset = 1'b1;
    ifc.PC = 16'h0000;
    ifc.instr_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_state("rst");

    // Zero-wait, two waits on a top-of-memory address, one wait.
    reset = 1'b0;
    fetch(16'h1000, 8'h34, 8'h12, 0, 3, "zero_wait");
    fetch(16'hFFFE, 8'hCD, 8'hAB, 2, 7, "wait2_top");
    fetch(16'h4AB6, 8'h5A, 8'hC3, 1, 5, "wait1");

    // Stall in VALID, then redirect with a new PC.
    mem[16'h0010] = 8'h78; mem[16'h0011] = 8'h56;
    mem[16'h0020] = 8'hEF; mem[16'h0021] = 8'hBE;
    wait_cfg = 0;
    ifc.PC = 16'h0010;
    ifc.instr_ready = 1'b0;
    addr_exp.push_back(16'h0010); addr_exp.push_back(16'h0011);
    addr_exp.push_back(16'h0020); addr_exp.push_back(16'h0021);
    wait_valid(n);
    chk("hold_latency", n, 3);
    chk("hold_instruction", ifc.instruction, 16'h5678);
    cyc(); cyc();
    chk("hold_valid", ifc.instr_valid, 1'b1);
    ifc.PC = 16'h0020;
    cyc();
    chk("redirect_valid_drop", ifc.instr_valid, 1'b0);
    chk("redirect_instr_kept", ifc.instruction, 16'h5678);
    ifc.instr_ready = 1'b1;
    sb.push_back(16'hBEEF);
    cyc();
    chk("redirect_req", ifc.mem_req, 1'b1);
    chk("redirect_addr", ifc.mem_addr, 16'h0020);
    wait_valid(n);
    chk("redirect_latency", n, 2);
    cyc();

    // Misaligned PC: sticky fault, no request ever.
    ifc.PC = 16'h0011;
    cyc();
    chk("misalign_fault", ifc.fault, 1'b1);
    chk("misalign_req", ifc.mem_req, 1'b0);
    ifc.PC = 16'h0040;
    bad = 1'b0;
    repeat (20) begin
      cyc();
      if (ifc.mem_req || !ifc.fault || ifc.instr_valid) bad = 1'b1;
    end
    chk("fault_sticky", bad, 1'b0);
    reset = 1'b1;
    cyc();
    chk_reset_state("rst2");

    // Unresponsive memory.
    reset = 1'b0;
    mem_en = 1'b0;
    ifc.PC = 16'h0100;
`ifdef FETCH_TIMEOUT_EN
    n = 0;
    do begin cyc(); n++; end while (!ifc.fault && n < 50);
    chk("timeout_cycles", n, 5);
    chk("timeout_req", ifc.mem_req, 1'b0);
`else
    bad = 1'b0;
    repeat (1000) begin
      cyc();
      if (!ifc.mem_req || ifc.fault || (ifc.mem_addr != 16'h0100)) bad = 1'b1;
    end
    chk("no_timeout_wait", bad, 1'b0);
`endif
    reset = 1'b1;
    cyc();

    // Reset while waiting on the high byte.
    reset = 1'b0;
    mem_en = 1'b1;
    wait_cfg = 3;
    mem[16'h2000] = 8'h11; mem[16'h2001] = 8'h22;
    ifc.PC = 16'h2000;
    addr_exp.push_back(16'h2000);
    n = 0;
    do begin cyc(); n++; end while (ifc.mem_addr != 16'h2001 && n < 50);
    chk("reach_req_hi", ifc.mem_addr, 16'h2001);
    reset = 1'b1;
    mem_en = 1'b0;
    cyc();
    chk_reset_state("rst_mid");

    // Stray ack in IDLE must not advance the new fetch.
    reset = 1'b0;
    stray_ack = 1'b1;
    mem_en = 1'b1;
    wait_cfg = 0;
    mem[16'h3000] = 8'h9A; mem[16'h3001] = 8'h78;
    ifc.PC = 16'h3000;
    addr_exp.push_back(16'h3000); addr_exp.push_back(16'h3001);
    sb.push_back(16'h789A);
    cyc();
    stray_ack = 1'b0;
    chk("stray_req", ifc.mem_req, 1'b1);
    chk("stray_addr", ifc.mem_addr, 16'h3000);
    wait_valid(n);
    chk("post_reset_latency", n, 2);
    ifc.instr_ready = 1'b1;
    cyc();
    ifc.instr_ready = 1'b0;
    mem_en = 1'b0;
    cyc();
    chk("sb_drained", sb.size(), 0);
    chk("addr_drained", addr_exp.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
